// File: rtl/ifu_if.sv
// Instruction-memory and decode-side handshake bundle for the ifu.
// The fault line exists only when IFU_ALIGN_CHECK_EN is defined.
interface ifu_if #(
    parameter int unsigned XLEN = 64
);
    logic            imem_req_o_ifu;
    logic [XLEN-1:0] imem_addr_o_ifu;
    logic            imem_gnt_i_ifu;
    logic            imem_rvalid_i_ifu;
    logic [31:0]     imem_rdata_i_ifu;

    logic            valid_o_ifu;
    logic            ready_i_ifu;
    logic [XLEN-1:0] pc_o_ifu;
    logic [31:0]     inst_o_ifu;
    logic [6:0]      opcode_o_ifu;
    logic [2:0]      func3_o_ifu;
    logic [6:0]      func7_o_ifu;
    logic [4:0]      rd_o_ifu;
    logic [4:0]      rs1_o_ifu;
    logic [4:0]      rs2_o_ifu;
    logic            jump_branch_i_ifu;
    logic [XLEN-1:0] target_i_ifu;
`ifdef IFU_ALIGN_CHECK_EN
    logic            fault_o_ifu;
`endif

    modport master (
`ifdef IFU_ALIGN_CHECK_EN
        output fault_o_ifu,
`endif
        output imem_req_o_ifu,
        output imem_addr_o_ifu,
        input  imem_gnt_i_ifu,
        input  imem_rvalid_i_ifu,
        input  imem_rdata_i_ifu,
        output valid_o_ifu,
        input  ready_i_ifu,
        output pc_o_ifu,
        output inst_o_ifu,
        output opcode_o_ifu,
        output func3_o_ifu,
        output func7_o_ifu,
        output rd_o_ifu,
        output rs1_o_ifu,
        output rs2_o_ifu,
        input  jump_branch_i_ifu,
        input  target_i_ifu
    );

    modport slave (
`ifdef IFU_ALIGN_CHECK_EN
        input  fault_o_ifu,
`endif
        input  imem_req_o_ifu,
        input  imem_addr_o_ifu,
        output imem_gnt_i_ifu,
        output imem_rvalid_i_ifu,
        output imem_rdata_i_ifu,
        input  valid_o_ifu,
        output ready_i_ifu,
        input  pc_o_ifu,
        input  inst_o_ifu,
        input  opcode_o_ifu,
        input  func3_o_ifu,
        input  func7_o_ifu,
        input  rd_o_ifu,
        input  rs1_o_ifu,
        input  rs2_o_ifu,
        output jump_branch_i_ifu,
        output target_i_ifu
    );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: single-outstanding fetch, instruction buffer, decode split, redirect.
// Optional misaligned-target fault enabled by defining IFU_ALIGN_CHECK_EN.
module ifu #(
    parameter int unsigned         XLEN     = 64,
    parameter logic [XLEN-1:0]     RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic  clk,
    input  logic  rst,
    ifu_if.master bus
);

    typedef enum logic [1:0] {
        ST_RST,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic            drop, drop_nxt;
    logic [31:0]     inst_q, inst_nxt;
    logic            redirect;
    logic [XLEN-1:0] target;

`ifdef IFU_ALIGN_CHECK_EN
    logic fault, fault_nxt;
    logic misaligned;

    // Once faulted the unit is parked; further redirects are ignored.
    assign redirect   = bus.jump_branch_i_ifu & ~fault;
    assign target     = bus.target_i_ifu;
    assign misaligned = |bus.target_i_ifu[1:0];
`else
    assign redirect   = bus.jump_branch_i_ifu;
    assign target     = bus.target_i_ifu & ~XLEN'(3);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_RST;
            pc     <= RESET_PC;
            drop   <= 1'b0;
            inst_q <= '0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            drop   <= drop_nxt;
            inst_q <= inst_nxt;
        end
    end

`ifdef IFU_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fault <= 1'b0;
        else      fault <= fault_nxt;
    end
`endif

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        drop_nxt  = drop;
        inst_nxt  = inst_q;
`ifdef IFU_ALIGN_CHECK_EN
        fault_nxt = fault;
`endif

        if (redirect) pc_nxt = target;

        case (state)
            ST_RST: begin
`ifdef IFU_ALIGN_CHECK_EN
                if (!fault) state_nxt = ST_REQ;
`else
                state_nxt = ST_REQ;
`endif
            end
            ST_REQ: begin
                if (bus.imem_gnt_i_ifu) begin
                    state_nxt = ST_WAIT;
                    if (redirect) drop_nxt = 1'b1;
                end
            end
            ST_WAIT: begin
                // A response coinciding with the redirect closes the fetch
                // itself, so the target is requested without waiting further.
                if (bus.imem_rvalid_i_ifu) begin
                    if (drop || redirect) begin
                        drop_nxt  = 1'b0;
                        state_nxt = ST_REQ;
                    end else begin
                        inst_nxt  = bus.imem_rdata_i_ifu;
                        state_nxt = ST_HOLD;
                    end
                end else if (redirect) begin
                    drop_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    state_nxt = ST_REQ;
                end else if (bus.ready_i_ifu) begin
                    pc_nxt    = pc + XLEN'(4);
                    state_nxt = ST_REQ;
                end
            end
            default: state_nxt = ST_RST;
        endcase

`ifdef IFU_ALIGN_CHECK_EN
        if (redirect && misaligned) begin
            fault_nxt = 1'b1;
            drop_nxt  = 1'b0;
            state_nxt = ST_RST;
        end
`endif
    end

    assign bus.imem_req_o_ifu  = (state == ST_REQ);
    assign bus.imem_addr_o_ifu = pc;
    assign bus.valid_o_ifu     = (state == ST_HOLD);
    assign bus.pc_o_ifu        = pc;
    assign bus.inst_o_ifu      = inst_q;
    assign bus.opcode_o_ifu    = inst_q[6:0];
    assign bus.func3_o_ifu     = inst_q[14:12];
    assign bus.func7_o_ifu     = inst_q[31:25];
    assign bus.rd_o_ifu        = inst_q[11:7];
    assign bus.rs1_o_ifu       = inst_q[19:15];
    assign bus.rs2_o_ifu       = inst_q[24:20];
`ifdef IFU_ALIGN_CHECK_EN
    assign bus.fault_o_ifu     = fault;
`endif

    a_addr_stable : assert property (@(posedge clk) disable iff (!rst)
        (bus.imem_req_o_ifu && !bus.imem_gnt_i_ifu && !bus.jump_branch_i_ifu)
        |=> (bus.imem_req_o_ifu && $stable(bus.imem_addr_o_ifu)));

    a_hold_stable : assert property (@(posedge clk) disable iff (!rst)
        (bus.valid_o_ifu && !bus.ready_i_ifu && !bus.jump_branch_i_ifu)
        |=> (bus.valid_o_ifu && $stable(bus.inst_o_ifu) && $stable(bus.pc_o_ifu)));

endmodule

// File: tb/tb_ifu.sv
// Scoreboard bench for ifu: the bench plays instruction memory and decoder.
module tb_ifu;

    localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic clk;
    logic rst;
    ifu_if #(.XLEN(64)) bus ();

    ifu #(.XLEN(64), .RESET_PC(RPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks;
    int          errors;
    exp_t        sb[$];
    logic [63:0] exp_pc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.imem_req_o_ifu === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL req_timeout actual no_request required request");
        end
    endtask

    task automatic serve(input logic [31:0] data, input int unsigned gdly, input string tag);
        bit          ok;
        logic [63:0] a;
        exp_t        e;
        wait_req(ok);
        if (!ok) return;
        a = bus.imem_addr_o_ifu;
        checks++;
        if (a !== exp_pc) begin
            errors++;
            $display("FAIL %s_addr actual %h required %h", tag, a, exp_pc);
        end
        for (int unsigned i = 0; i < gdly; i++) begin
            @(negedge clk);
            checks++;
            if (bus.imem_req_o_ifu !== 1'b1 || bus.imem_addr_o_ifu !== a) begin
                errors++;
                $display("FAIL %s_req_hold actual %b/%h required 1/%h", tag,
                         bus.imem_req_o_ifu, bus.imem_addr_o_ifu, a);
            end
        end
        bus.imem_gnt_i_ifu = 1'b1;
        e.pc   = exp_pc;
        e.inst = data;
        sb.push_back(e);
        @(negedge clk);
        bus.imem_gnt_i_ifu    = 1'b0;
        bus.imem_rvalid_i_ifu = 1'b1;
        bus.imem_rdata_i_ifu  = data;
        @(negedge clk);
        bus.imem_rvalid_i_ifu = 1'b0;
        bus.imem_rdata_i_ifu  = '0;
    endtask

    task automatic consume(input string tag);
        exp_t e;
        checks++;
        if (bus.valid_o_ifu !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL %s_valid actual %b (queued %0d) required 1", tag, bus.valid_o_ifu, sb.size());
            return;
        end
        e = sb.pop_front();
        checks++;
        if (bus.pc_o_ifu !== e.pc || bus.inst_o_ifu !== e.inst) begin
            errors++;
            $display("FAIL %s_data actual %h/%h required %h/%h", tag,
                     bus.pc_o_ifu, bus.inst_o_ifu, e.pc, e.inst);
        end
        checks++;
        if ({bus.opcode_o_ifu, bus.func3_o_ifu, bus.func7_o_ifu, bus.rd_o_ifu, bus.rs1_o_ifu, bus.rs2_o_ifu}
            !== {e.inst[6:0], e.inst[14:12], e.inst[31:25], e.inst[11:7], e.inst[19:15], e.inst[24:20]}) begin
            errors++;
            $display("FAIL %s_fields actual %h required slices of %h", tag,
                     {bus.opcode_o_ifu, bus.func3_o_ifu, bus.func7_o_ifu, bus.rd_o_ifu, bus.rs1_o_ifu, bus.rs2_o_ifu},
                     e.inst);
        end
        bus.ready_i_ifu = 1'b1;
        @(negedge clk);
        bus.ready_i_ifu = 1'b0;
        exp_pc = exp_pc + 64'd4;
        checks++;
        if (bus.valid_o_ifu !== 1'b0) begin
            errors++;
            $display("FAIL %s_valid_drop actual %b required 0", tag, bus.valid_o_ifu);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.imem_req_o_ifu !== 1'b0 || bus.valid_o_ifu !== 1'b0 ||
            bus.imem_addr_o_ifu !== RPC || bus.pc_o_ifu !== RPC || bus.inst_o_ifu !== 32'h0 ||
            {bus.opcode_o_ifu, bus.func3_o_ifu, bus.func7_o_ifu, bus.rd_o_ifu, bus.rs1_o_ifu, bus.rs2_o_ifu} !== '0) begin
            errors++;
            $display("FAIL reset_outputs actual req=%b valid=%b addr=%h pc=%h inst=%h required 0/0/%h/%h/0",
                     bus.imem_req_o_ifu, bus.valid_o_ifu, bus.imem_addr_o_ifu, bus.pc_o_ifu, bus.inst_o_ifu, RPC, RPC);
        end
`ifdef IFU_ALIGN_CHECK_EN
        checks++;
        if (bus.fault_o_ifu !== 1'b0) begin
            errors++;
            $display("FAIL reset_fault actual %b required 0", bus.fault_o_ifu);
        end
`endif
        rst = 1'b1;
        exp_pc = RPC;
        @(negedge clk);
        checks++;
        if (bus.imem_req_o_ifu !== 1'b1 || bus.imem_addr_o_ifu !== RPC) begin
            errors++;
            $display("FAIL reset_first_req actual %b/%h required 1/%h", bus.imem_req_o_ifu, bus.imem_addr_o_ifu, RPC);
        end
    endtask

    task automatic test_first_fetch;
        serve(32'h0050_0093, 0, "first");
        checks++;
        if (bus.valid_o_ifu !== 1'b1 || bus.opcode_o_ifu !== 7'b0010011 || bus.func3_o_ifu !== 3'b000 ||
            bus.rd_o_ifu !== 5'd1 || bus.rs1_o_ifu !== 5'd0) begin
            errors++;
            $display("FAIL first_decode actual v=%b op=%b f3=%b rd=%0d rs1=%0d required 1/0010011/000/1/0",
                     bus.valid_o_ifu, bus.opcode_o_ifu, bus.func3_o_ifu, bus.rd_o_ifu, bus.rs1_o_ifu);
        end
    endtask

    task automatic test_stall;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.valid_o_ifu !== 1'b1 || bus.imem_req_o_ifu !== 1'b0 ||
                bus.inst_o_ifu !== 32'h0050_0093 || bus.pc_o_ifu !== RPC) begin
                errors++;
                $display("FAIL stall_hold actual v=%b req=%b inst=%h pc=%h required 1/0/00500093/%h",
                         bus.valid_o_ifu, bus.imem_req_o_ifu, bus.inst_o_ifu, bus.pc_o_ifu, RPC);
            end
            @(negedge clk);
        end
        consume("stall");
        serve(32'h00a0_0113, 0, "after_stall");
        consume("after_stall");
    endtask

    task automatic test_redirect_wait;
        bit ok;
        wait_req(ok);
        if (!ok) return;
        bus.imem_gnt_i_ifu = 1'b1;
        @(negedge clk);
        bus.imem_gnt_i_ifu    = 1'b0;
        bus.jump_branch_i_ifu = 1'b1;
        bus.target_i_ifu      = 64'h0000_0000_8000_0100;
        exp_pc                = 64'h0000_0000_8000_0100;
        @(negedge clk);
        bus.jump_branch_i_ifu = 1'b0;
        bus.imem_rvalid_i_ifu = 1'b1;
        bus.imem_rdata_i_ifu  = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.imem_rvalid_i_ifu = 1'b0;
        checks++;
        if (bus.valid_o_ifu !== 1'b0 || bus.inst_o_ifu === 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wait_drop actual v=%b inst=%h required 0/not deadbeef", bus.valid_o_ifu, bus.inst_o_ifu);
        end
        serve(32'h0000_0013, 1, "wait_redirect");
        consume("wait_redirect");

        wait_req(ok);
        if (!ok) return;
        bus.imem_gnt_i_ifu = 1'b1;
        @(negedge clk);
        bus.imem_gnt_i_ifu    = 1'b0;
        bus.jump_branch_i_ifu = 1'b1;
        bus.target_i_ifu      = 64'h0000_0000_8000_0180;
        bus.imem_rvalid_i_ifu = 1'b1;
        bus.imem_rdata_i_ifu  = 32'hDEAD_BEEF;
        exp_pc                = 64'h0000_0000_8000_0180;
        @(negedge clk);
        bus.jump_branch_i_ifu = 1'b0;
        bus.imem_rvalid_i_ifu = 1'b0;
        checks++;
        if (bus.valid_o_ifu !== 1'b0 || bus.imem_req_o_ifu !== 1'b1 || bus.imem_addr_o_ifu !== exp_pc) begin
            errors++;
            $display("FAIL wait_same_cycle actual v=%b req=%b addr=%h required 0/1/%h",
                     bus.valid_o_ifu, bus.imem_req_o_ifu, bus.imem_addr_o_ifu, exp_pc);
        end
        serve(32'h0011_8193, 0, "wait_same");
        consume("wait_same");
    endtask

    task automatic test_redirect_hold;
        exp_t killed;
        serve(32'h1234_5678, 0, "hold_pre");
        bus.jump_branch_i_ifu = 1'b1;
        bus.ready_i_ifu       = 1'b1;
        bus.target_i_ifu      = 64'h0000_0000_8000_0200;
        @(negedge clk);
        bus.jump_branch_i_ifu = 1'b0;
        bus.ready_i_ifu       = 1'b0;
        if (sb.size() != 0) killed = sb.pop_front();
        exp_pc = 64'h0000_0000_8000_0200;
        checks++;
        if (bus.valid_o_ifu !== 1'b0 || bus.imem_addr_o_ifu !== exp_pc) begin
            errors++;
            $display("FAIL hold_redirect actual v=%b addr=%h required 0/%h (killed pc %h)",
                     bus.valid_o_ifu, bus.imem_addr_o_ifu, exp_pc, killed.pc);
        end
        serve(32'h0020_8233, 0, "hold_redirect");
        consume("hold_redirect");
    endtask

    task automatic test_req_redirect;
        bus.jump_branch_i_ifu = 1'b1;
        bus.target_i_ifu      = 64'h0000_0000_8000_0300;
        exp_pc                = 64'h0000_0000_8000_0300;
        @(negedge clk);
        bus.jump_branch_i_ifu = 1'b0;
        checks++;
        if (bus.imem_req_o_ifu !== 1'b1 || bus.imem_addr_o_ifu !== exp_pc) begin
            errors++;
            $display("FAIL req_redirect actual %b/%h required 1/%h", bus.imem_req_o_ifu, bus.imem_addr_o_ifu, exp_pc);
        end
        bus.imem_gnt_i_ifu    = 1'b1;
        bus.jump_branch_i_ifu = 1'b1;
        bus.target_i_ifu      = 64'h0000_0000_8000_0400;
        exp_pc                = 64'h0000_0000_8000_0400;
        @(negedge clk);
        bus.imem_gnt_i_ifu    = 1'b0;
        bus.jump_branch_i_ifu = 1'b0;
        bus.imem_rvalid_i_ifu = 1'b1;
        bus.imem_rdata_i_ifu  = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.imem_rvalid_i_ifu = 1'b0;
        checks++;
        if (bus.valid_o_ifu !== 1'b0 || bus.imem_req_o_ifu !== 1'b1 || bus.imem_addr_o_ifu !== exp_pc) begin
            errors++;
            $display("FAIL req_gnt_redirect actual v=%b req=%b addr=%h required 0/1/%h",
                     bus.valid_o_ifu, bus.imem_req_o_ifu, bus.imem_addr_o_ifu, exp_pc);
        end
        serve(32'h4000_0033, 2, "req_gnt_redirect");
        consume("req_gnt_redirect");
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 6; i++) begin
            serve($urandom, i % 3, "b2b");
            consume("b2b");
            checks++;
            if (bus.imem_req_o_ifu !== 1'b1 || bus.imem_addr_o_ifu !== exp_pc) begin
                errors++;
                $display("FAIL b2b_next_req actual %b/%h required 1/%h", bus.imem_req_o_ifu, bus.imem_addr_o_ifu, exp_pc);
            end
        end
    endtask

    task automatic test_wrap;
        bus.jump_branch_i_ifu = 1'b1;
        bus.target_i_ifu      = 64'hFFFF_FFFF_FFFF_FFFC;
        exp_pc                = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk);
        bus.jump_branch_i_ifu = 1'b0;
        serve(32'h0000_0073, 0, "wrap_top");
        consume("wrap_top");
        checks++;
        if (exp_pc !== 64'h0 || bus.imem_addr_o_ifu !== 64'h0) begin
            errors++;
            $display("FAIL wrap_addr actual %h required 0000000000000000", bus.imem_addr_o_ifu);
        end
        serve(32'h0000_0013, 0, "wrap_zero");
        consume("wrap_zero");
    endtask

    task automatic test_mid_reset;
        bit ok;
        wait_req(ok);
        if (!ok) return;
        bus.imem_gnt_i_ifu = 1'b1;
        @(negedge clk);
        bus.imem_gnt_i_ifu = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.imem_req_o_ifu !== 1'b0 || bus.valid_o_ifu !== 1'b0 || bus.pc_o_ifu !== RPC ||
            bus.imem_addr_o_ifu !== RPC || bus.inst_o_ifu !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset actual req=%b v=%b pc=%h addr=%h inst=%h required 0/0/%h/%h/0",
                     bus.imem_req_o_ifu, bus.valid_o_ifu, bus.pc_o_ifu, bus.imem_addr_o_ifu, bus.inst_o_ifu, RPC, RPC);
        end
        @(negedge clk);
        rst = 1'b1;
        exp_pc = RPC;
        sb.delete();
        serve(32'h0050_0093, 0, "post_reset");
        consume("post_reset");
    endtask

    task automatic test_misaligned;
        exp_t killed;
        int   reqs;
        serve(32'h0031_0113, 0, "misalign_pre");
        bus.jump_branch_i_ifu = 1'b1;
        bus.target_i_ifu      = 64'h0000_0000_8000_0002;
        @(negedge clk);
        bus.jump_branch_i_ifu = 1'b0;
        if (sb.size() != 0) killed = sb.pop_front();
`ifdef IFU_ALIGN_CHECK_EN
        checks++;
        if (bus.fault_o_ifu !== 1'b1 || bus.valid_o_ifu !== 1'b0) begin
            errors++;
            $display("FAIL misalign_fault actual f=%b v=%b required 1/0", bus.fault_o_ifu, bus.valid_o_ifu);
        end
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.imem_req_o_ifu !== 1'b0 || bus.fault_o_ifu !== 1'b1) reqs++;
            @(negedge clk);
        end
        checks++;
        if (reqs != 0) begin
            errors++;
            $display("FAIL misalign_parked actual %0d bad cycles required 0", reqs);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_pc = RPC;
        checks++;
        if (bus.fault_o_ifu !== 1'b0) begin
            errors++;
            $display("FAIL fault_clear actual %b required 0", bus.fault_o_ifu);
        end
        serve(32'h0050_0093, 0, "after_fault");
        consume("after_fault");
`else
        reqs   = 0;
        exp_pc = 64'h0000_0000_8000_0000;
        serve(32'h0050_0093, 0, "misalign_forced");
        consume("misalign_forced");
        checks++;
        if (killed.pc !== 64'h0000_0000_8000_0000 + 64'h0 * 64'(reqs) && killed.pc === 64'hx) begin
            errors++;
            $display("FAIL misalign_kill actual %h required defined pc", killed.pc);
        end
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_pc = RPC;
        rst = 1'b0;
        bus.imem_gnt_i_ifu    = 1'b0;
        bus.imem_rvalid_i_ifu = 1'b0;
        bus.imem_rdata_i_ifu  = '0;
        bus.ready_i_ifu       = 1'b0;
        bus.jump_branch_i_ifu = 1'b0;
        bus.target_i_ifu      = '0;

        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_req_redirect();
        test_back_to_back();
        test_wrap();
        test_mid_reset();
        test_misaligned();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual running required finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit feeding the control/decode stage of the NPC core. It holds the PC and issues one fetch at a time to instruction memory over a request/grant + response handshake. It buffers the returned instruction word and presents it, split into opcode/func3/func7/register fields, to the decoder with a valid/ready handshake. It redirects the PC when the decoder's jump/branch signal asserts, discarding any fetch already in flight.

## Interface
- `RESET_PC`, default 64'h0000_0000_8000_0000: PC loaded at reset.
- `XLEN`, default 64: PC/address width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `imem_req_o_ifu` out 1: fetch request.
- `imem_addr_o_ifu` out XLEN: fetch address; stable while request is pending.
- `imem_gnt_i_ifu` in 1: request accepted this cycle.
- `imem_rvalid_i_ifu` in 1: response data valid; one per grant, at least 1 cycle after grant.
- `imem_rdata_i_ifu` in 32: instruction word.
- `valid_o_ifu` out 1: decode outputs hold a valid instruction.
- `ready_i_ifu` in 1: decoder consumes the instruction this cycle.
- `pc_o_ifu` out XLEN: PC of the presented instruction.
- `inst_o_ifu` out 32: raw instruction.
- `opcode_o_ifu` out 7: inst[6:0].
- `func3_o_ifu` out 3: inst[14:12].
- `func7_o_ifu` out 7: inst[31:25].
- `rd_o_ifu`, `rs1_o_ifu`, `rs2_o_ifu` out 5 each: inst[11:7], inst[19:15], inst[24:20].
- `jump_branch_i_ifu` in 1: redirect strobe from the decode stage.
- `target_i_ifu` in XLEN: redirect target, sampled when `jump_branch_i_ifu` is 1.
- `fault_o_ifu` out 1: misaligned-target fault. Present only with `IFU_ALIGN_CHECK_EN`.

## Operation
- The FSM has four states:
  - RST: entered on reset.
  - REQ: drive the request.
  - WAIT: await the response.
  - HOLD: instruction presented to the decoder.
- RST→REQ unconditionally on the first clock after reset is released.
- REQ: `imem_req_o_ifu`=1 and `imem_addr_o_ifu`=pc. On gnt, go to WAIT.
- WAIT: on rvalid with drop=0, capture rdata into the buffer and go to HOLD. On rvalid with drop=1, discard the data, clear drop, and go to REQ.
- HOLD: `valid_o_ifu`=1. On ready, pc ← pc+4 (modulo 2^XLEN) and go to REQ.
- Redirect (`jump_branch_i_ifu`=1) behaviour by state. Redirect has priority over ready and gnt.
  - Any state: pc ← target at the next edge.
  - REQ without gnt: the next request uses the target address.
  - REQ with gnt in the same cycle: go to WAIT with drop=1.
  - WAIT: set drop=1 and stay in WAIT. An rvalid arriving in the same cycle as the redirect is discarded.
  - HOLD: invalidate the buffer and go to REQ. `valid_o_ifu`=0 next cycle; a simultaneous ready is ignored and the PC does not increment.
- Decode fields are pure slices of the buffer register. They are valid only while `valid_o_ifu`=1.
- At most one outstanding fetch at any time.

## Timing
- Reset values:
  - All outputs 0, except `pc_o_ifu`=RESET_PC and `imem_addr_o_ifu`=RESET_PC.
  - Internal pc=RESET_PC, drop=0, buffer=0.
- Latency, no stalls: req at cycle N, gnt at N, rvalid at N+1, `valid_o_ifu`=1 at N+2. After ready at N+2, the next req is at N+3. Throughput is 1 instruction per 3 cycles with single-cycle memory.
- `valid_o_ifu`, `inst_o_ifu` and `pc_o_ifu` are registered and held stable until ready or redirect.
- Reset asserted mid-operation: immediate return to RST with all state cleared. A late rvalid for a pre-reset request must not occur; the memory shares the same reset.

## Configuration
- `IFU_ALIGN_CHECK_EN`
  - Defined: a redirect with target[1:0]≠0 sets `fault_o_ifu`=1 (sticky until reset). The FSM parks in RST-like idle with no further requests; pc is still loaded with the target.
  - Undefined: no fault port. target[1:0] is forced to 2'b00 on load.

## Test plan
- Reset release with RESET_PC=0x8000_0000 and a single-cycle memory returning 0x00500093 → first request addr 0x8000_0000. `valid_o_ifu`=1 two cycles after gnt, with opcode=0010011, func3=000, rd=1, rs1=0.
- Hold ready=0 for 5 cycles → outputs stable; no new request. Then ready=1 → next request addr 0x8000_0004.
- Redirect to 0x8000_0100 while in WAIT, then rvalid with 0xDEADBEEF → data dropped; next request addr 0x8000_0100; `valid_o_ifu` never shows 0xDEADBEEF.
- Redirect and ready in the same HOLD cycle → `valid_o_ifu`=0 next cycle; next request addr = target, not pc+4.
- pc=0xFFFF_FFFF_FFFF_FFFC consumed → next addr wraps to 0x0.
- With `IFU_ALIGN_CHECK_EN`: redirect to 0x8000_0002 → `fault_o_ifu`=1; no further `imem_req_o_ifu`. Without the macro: next request addr 0x8000_0000.
